// File: rtl/dkongjr_col_mix_if.sv
// Pixel, palette-bank and palette-download signals of the colour mixer.
// Master drives the pixel/config inputs; slave (the mixer) drives RGB out.
interface dkongjr_col_mix_if;
    logic       I_H_CNT0;
    logic       I_CMPBLK;
    logic [1:0] I_VID;
    logic [3:0] I_COL;
    logic [5:0] I_OBJ;
    logic       I_CBNK_WE;
    logic       I_CBNK_A;
    logic       I_CBNK_D;
    logic       I_CNF_EN;
    logic [8:0] I_CNF_A;
    logic [3:0] I_CNF_D;
    logic       I_CNF_WE;
    logic [2:0] O_R;
    logic [2:0] O_G;
    logic [1:0] O_B;
    logic       O_BLANK;

    modport master (
        output I_H_CNT0, I_CMPBLK, I_VID, I_COL, I_OBJ,
        output I_CBNK_WE, I_CBNK_A, I_CBNK_D,
        output I_CNF_EN, I_CNF_A, I_CNF_D, I_CNF_WE,
        input  O_R, O_G, O_B, O_BLANK
    );

    modport slave (
        input  I_H_CNT0, I_CMPBLK, I_VID, I_COL, I_OBJ,
        input  I_CBNK_WE, I_CBNK_A, I_CBNK_D,
        input  I_CNF_EN, I_CNF_A, I_CNF_D, I_CNF_WE,
        output O_R, O_G, O_B, O_BLANK
    );
endinterface

// File: rtl/dkongjr_col_mix.sv
// Donkey Kong Jr final colour stage: sprite/background priority,
// banked 256-entry palette lookup, blanking and registered RGB.
module dkongjr_col_mix (
    input  logic             CLK_12M,
    input  logic             I_RESETn,
    dkongjr_col_mix_if.slave bus
);
    logic       h0_d;
    logic       pix_ce;
    logic [1:0] cbnk;
    logic [7:0] idx;
    logic [7:0] idx_nxt;
    logic       blk_a;
    logic [3:0] pal_hi [256];
    logic [3:0] pal_lo [256];
    logic [3:0] hi_q;
    logic [3:0] lo_q;
    logic [2:0] r_nxt;
    logic [2:0] g_nxt;
    logic [1:0] b_nxt;

    assign pix_ce = bus.I_H_CNT0 & ~h0_d;

    always_ff @(posedge CLK_12M or negedge I_RESETn) begin
        if (!I_RESETn) begin
            h0_d <= 1'b0;
        end else begin
            h0_d <= bus.I_H_CNT0;
        end
    end

    always_ff @(posedge CLK_12M or negedge I_RESETn) begin
        if (!I_RESETn) begin
            cbnk <= 2'b00;
        end else if (bus.I_CBNK_WE) begin
            cbnk[bus.I_CBNK_A] <= bus.I_CBNK_D;
        end
    end

    // A non-transparent sprite pixel overrides the background.
    always_comb begin
        idx_nxt = {cbnk, bus.I_COL, bus.I_VID};
        if (bus.I_OBJ[1:0] != 2'b00) begin
            idx_nxt = {cbnk, bus.I_OBJ};
        end
    end

    always_ff @(posedge CLK_12M or negedge I_RESETn) begin
        if (!I_RESETn) begin
            idx   <= 8'h00;
            blk_a <= 1'b1;
        end else if (pix_ce) begin
            idx   <= idx_nxt;
            blk_a <= bus.I_CMPBLK | bus.I_CNF_EN;
        end
    end

    // Palette survives reset; same-entry write/read yields the old word.
    always_ff @(posedge CLK_12M) begin
        if (bus.I_CNF_EN && bus.I_CNF_WE) begin
            if (bus.I_CNF_A[8]) begin
                pal_hi[bus.I_CNF_A[7:0]] <= bus.I_CNF_D;
            end else begin
                pal_lo[bus.I_CNF_A[7:0]] <= bus.I_CNF_D;
            end
        end
        hi_q <= pal_hi[idx];
        lo_q <= pal_lo[idx];
    end

    // PROM words are stored inverted.
    always_comb begin
        r_nxt = 3'd0;
        g_nxt = 3'd0;
        b_nxt = 2'd0;
        if (!blk_a) begin
            r_nxt = ~hi_q[3:1];
            g_nxt = ~{hi_q[0], lo_q[3:2]};
            b_nxt = ~lo_q[1:0];
        end
    end

    always_ff @(posedge CLK_12M or negedge I_RESETn) begin
        if (!I_RESETn) begin
            bus.O_R     <= 3'd0;
            bus.O_G     <= 3'd0;
            bus.O_B     <= 2'd0;
            bus.O_BLANK <= 1'b1;
        end else if (pix_ce) begin
            bus.O_R     <= r_nxt;
            bus.O_G     <= g_nxt;
            bus.O_B     <= b_nxt;
            bus.O_BLANK <= blk_a;
        end
    end
endmodule

// File: tb/tb_dkongjr_col_mix.sv
// Directed bench for dkongjr_col_mix: palette load, priority, bank,
// blanking, config forcing, write/read collision and mid-line reset.
module tb_dkongjr_col_mix;
    logic CLK_12M = 1'b0;
    logic I_RESETn;
    int   n_vec = 0;
    int   n_err = 0;

    dkongjr_col_mix_if bus ();

    dkongjr_col_mix dut (
        .CLK_12M (CLK_12M),
        .I_RESETn(I_RESETn),
        .bus     (bus.slave)
    );

    always #5 CLK_12M = ~CLK_12M;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rgb();
        return {bus.O_R, bus.O_G, bus.O_B};
    endfunction

    task automatic pix();
        @(negedge CLK_12M) bus.I_H_CNT0 = 1'b1;
        @(negedge CLK_12M) bus.I_H_CNT0 = 1'b0;
    endtask

    task automatic pix_bank(input logic a, input logic d);
        @(negedge CLK_12M);
        bus.I_H_CNT0  = 1'b1;
        bus.I_CBNK_WE = 1'b1;
        bus.I_CBNK_A  = a;
        bus.I_CBNK_D  = d;
        @(negedge CLK_12M);
        bus.I_H_CNT0  = 1'b0;
        bus.I_CBNK_WE = 1'b0;
    endtask

    task automatic wcbnk(input logic a, input logic d);
        @(negedge CLK_12M);
        bus.I_CBNK_WE = 1'b1;
        bus.I_CBNK_A  = a;
        bus.I_CBNK_D  = d;
        @(negedge CLK_12M) bus.I_CBNK_WE = 1'b0;
    endtask

    task automatic wcnf(input logic [8:0] a, input logic [3:0] d);
        @(negedge CLK_12M);
        bus.I_CNF_WE = 1'b1;
        bus.I_CNF_A  = a;
        bus.I_CNF_D  = d;
        @(negedge CLK_12M) bus.I_CNF_WE = 1'b0;
    endtask

    task automatic load(input logic [7:0] e, input logic [3:0] hi,
                        input logic [3:0] lo);
        wcnf({1'b1, e}, hi);
        wcnf({1'b0, e}, lo);
    endtask

    initial begin
        int pat [7] = '{0, 1, 1, 1, 0, 0, 0};
        int prv;
        I_RESETn      = 1'b0;
        bus.I_H_CNT0  = 1'b0;
        bus.I_CMPBLK  = 1'b0;
        bus.I_VID     = 2'd0;
        bus.I_COL     = 4'd0;
        bus.I_OBJ     = 6'd0;
        bus.I_CBNK_WE = 1'b0;
        bus.I_CBNK_A  = 1'b0;
        bus.I_CBNK_D  = 1'b0;
        bus.I_CNF_EN  = 1'b0;
        bus.I_CNF_A   = 9'd0;
        bus.I_CNF_D   = 4'd0;
        bus.I_CNF_WE  = 1'b0;
        repeat (3) @(negedge CLK_12M);
        chk("rst_rgb", rgb(), 8'h00);
        chk("rst_blank", bus.O_BLANK, 1'b1);
        I_RESETn = 1'b1;

        // palette download; strobes keep running but output stays black
        bus.I_CNF_EN = 1'b1;
        load(8'h25, 4'h0, 4'h0);
        load(8'h2A, 4'hF, 4'hC);
        load(8'hA5, 4'h5, 4'hA);
        bus.I_OBJ = 6'h25;
        pix();
        pix();
        chk("cnf_rgb", rgb(), 8'h00);
        chk("cnf_blank", bus.O_BLANK, 1'b1);
        bus.I_CNF_EN = 1'b0;
        pix();
        chk("rel1_blank", bus.O_BLANK, 1'b1);
        chk("rel1_rgb", rgb(), 8'h00);
        pix();
        chk("rel2_rgb", rgb(), 8'hFF);
        chk("rel2_blank", bus.O_BLANK, 1'b0);

        // background path: idx {00, A, 2} = 0x2A -> R0 G0 B3
        bus.I_OBJ = 6'h00;
        bus.I_COL = 4'hA;
        bus.I_VID = 2'd2;
        pix();
        chk("bg_lag", rgb(), 8'hFF);
        pix();
        chk("bg_rgb", rgb(), 8'h03);
        bus.I_OBJ = 6'h25;
        pix();
        chk("spr_lag", rgb(), 8'h03);
        pix();
        chk("spr_rgb", rgb(), 8'hFF);

        // bank write coincident with strobe: old bank used there
        pix_bank(1'b1, 1'b1);
        chk("bank_s0", rgb(), 8'hFF);
        pix();
        chk("bank_s1", rgb(), 8'hFF);
        pix();
        chk("bank_s2", rgb(), 8'hA5);
        wcbnk(1'b1, 1'b0);
        pix();
        pix();
        chk("bank_clr", rgb(), 8'hFF);

        // composite blank pulse, outputs lag by one strobe
        prv = 0;
        for (int i = 0; i < 7; i++) begin
            bus.I_CMPBLK = pat[i][0];
            pix();
            chk($sformatf("blk%0d_b", i), bus.O_BLANK, prv[0]);
            chk($sformatf("blk%0d_c", i), rgb(), prv != 0 ? 8'h00 : 8'hFF);
            prv = pat[i];
        end
        bus.I_CMPBLK = 1'b0;

        // config mode entered mid-line
        bus.I_CNF_EN = 1'b1;
        pix();
        chk("fc1_rgb", rgb(), 8'hFF);
        pix();
        chk("fc2_rgb", rgb(), 8'h00);
        chk("fc2_blank", bus.O_BLANK, 1'b1);
        bus.I_CNF_EN = 1'b0;
        pix();
        pix();
        chk("fc_back", rgb(), 8'hFF);

        // rewrite hi of 0x25 on the clock it is read: strobe sees old word
        @(negedge CLK_12M) bus.I_H_CNT0 = 1'b1;
        @(negedge CLK_12M);
        bus.I_H_CNT0 = 1'b0;
        bus.I_CNF_EN = 1'b1;
        bus.I_CNF_WE = 1'b1;
        bus.I_CNF_A  = 9'h125;
        bus.I_CNF_D  = 4'hE;
        @(negedge CLK_12M);
        bus.I_H_CNT0 = 1'b1;
        bus.I_CNF_WE = 1'b0;
        bus.I_CNF_EN = 1'b0;
        @(negedge CLK_12M) bus.I_H_CNT0 = 1'b0;
        chk("coll_old", rgb(), 8'hFF);
        pix();
        chk("coll_new", rgb(), 8'h1F);

        // mid-line reset with bank bit1 set
        wcbnk(1'b1, 1'b1);
        pix();
        pix();
        chk("pre_rst", rgb(), 8'hA5);
        @(negedge CLK_12M) bus.I_H_CNT0 = 1'b1;
        #2 I_RESETn = 1'b0;
        #1;
        chk("mid_rst_rgb", rgb(), 8'h00);
        chk("mid_rst_blank", bus.O_BLANK, 1'b1);
        @(negedge CLK_12M) bus.I_H_CNT0 = 1'b0;
        @(negedge CLK_12M) I_RESETn = 1'b1;
        pix();
        chk("post1_blank", bus.O_BLANK, 1'b1);
        chk("post1_rgb", rgb(), 8'h00);
        pix();
        chk("post2_rgb", rgb(), 8'h1F);
        chk("post2_blank", bus.O_BLANK, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
